i2s_receiver: RTL and testbench

Captures stereo PCM from the ADAU ADC serial output (`ac_adc_sdata`) in I2S format and delivers it to the SoC as left/right frame pairs over a valid/ready stream. It is the receive counterpart of `i2s_master`. `i2s_master` drives `bclk`/`lrclk`, and this block taps those same pins as inputs, oversampling them in the SoC clock domain. A small FIFO decouples the audio rate from the consumer, for example a DSP block or a picorv32 peripheral.

---
 rtl/i2s_receiver.sv | 237 +++++++++++++++++++++++
 tb/tb_i2s_receiver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
`timescale 1ns / 1ps
// i2s_receiver
//   Captures stereo PCM from an I2S serial stream (bclk/lrclk/sdata driven by
//   an external master) by oversampling the bus in the SoC clock domain, and
//   delivers left/right pairs through a first-word-fall-through frame FIFO
//   with a valid/ready handshake.
//
// Ports
//   clk            : SoC clock, at least 8x the bclk frequency
//   reset          : synchronous, active-high reset
//   bclk           : I2S bit clock (asynchronous input)
//   lrclk          : I2S word select, 0 = left slot, 1 = right slot
//   sdata          : I2S serial data, MSB first, one-bit delay after lrclk edge
//   frame_out_l    : left sample at the FIFO head (0 while empty)
//   frame_out_r    : right sample at the FIFO head (0 while empty)
//   valid          : FIFO non-empty
//   ready          : consumer takes the head frame when valid && ready
//   level          : FIFO fill count
//   locked         : a complete L/R frame has been captured since the last error
//   overflow_count : frames dropped on a full FIFO, saturating at 255
module i2s_receiver #(
  parameter int WIDTH       = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bclk,
  input  logic                          lrclk,
  input  logic                          sdata,
  output logic [WIDTH-1:0]              frame_out_l,
  output logic [WIDTH-1:0]              frame_out_r,
  output logic                          valid,
  input  logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          locked,
  output logic [7:0]                    overflow_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    WAIT_SYNC,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ---- Stage p0: input synchronizers and bclk rising-edge detect ----
  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lr_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   bclk_d;
  logic                   bclk_s;
  logic                   lr_s;
  logic                   sd_s;
  logic                   bclk_rise;

  always_ff @(posedge clk) begin
    bclk_sync[0] <= bclk;
    lr_sync[0]   <= lrclk;
    sd_sync[0]   <= sdata;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      bclk_sync[i] <= bclk_sync[i-1];
      lr_sync[i]   <= lr_sync[i-1];
      sd_sync[i]   <= sd_sync[i-1];
    end
    bclk_d <= bclk_sync[SYNC_STAGES-1];
  end

  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign lr_s      = lr_sync[SYNC_STAGES-1];
  assign sd_s      = sd_sync[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_d;

  // ---- Stage p0: slot framing FSM and shift register ----
  state_t          state_q;
  state_t          state_d;
  logic            lr_prev;
  logic            primed;      // lr_prev holds a real sample taken after reset
  logic            slot_lr;     // which slot the word being assembled belongs to
  logic [CW-1:0]   bit_cnt;
  logic [WIDTH-1:0] shift_p0;
  logic            lr_change;
  logic            start_slot;
  logic            short_slot;
  logic            shift_en;
  logic            last_bit;

  assign lr_change = (lr_s != lr_prev);

  always_comb begin
    state_d    = state_q;
    start_slot = 1'b0;
    short_slot = 1'b0;
    shift_en   = 1'b0;
    last_bit   = 1'b0;
    if (bclk_rise) begin
      unique case (state_q)
        WAIT_SYNC: begin
          // The rise that shows the lrclk change is the I2S delay bit.
          if (primed && lr_change) begin
            state_d    = SHIFT;
            start_slot = 1'b1;
          end
        end
        SHIFT: begin
          if (lr_change) begin
            short_slot = 1'b1;
            start_slot = 1'b1;
          end else begin
            shift_en = 1'b1;
            if (bit_cnt == CW'(WIDTH - 1)) begin
              state_d  = DONE;
              last_bit = 1'b1;
            end
          end
        end
        DONE: begin
          if (lr_change) begin
            state_d    = SHIFT;
            start_slot = 1'b1;
          end
        end
        default: state_d = WAIT_SYNC;
      endcase
    end
  end

  // ---- Stage p1: word commit (left hold / right pairing) ----
  logic             vld_p1;
  logic [WIDTH-1:0] hold_l;
  logic             left_ok;
  logic             push;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_SYNC;
      lr_prev <= 1'b0;
      primed  <= 1'b0;
      slot_lr <= 1'b0;
      bit_cnt <= '0;
      vld_p1  <= 1'b0;
      left_ok <= 1'b0;
      locked  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= last_bit;
      if (bclk_rise) begin
        lr_prev <= lr_s;
        primed  <= 1'b1;
      end
      if (start_slot) begin
        bit_cnt <= '0;
        slot_lr <= lr_s;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      // A commit cycle never coincides with a bclk rise, so short-slot
      // detection and commit are mutually exclusive.
      if (short_slot) begin
        left_ok <= 1'b0;
        locked  <= 1'b0;
      end else if (vld_p1) begin
        if (!slot_lr) begin
          left_ok <= 1'b1;
        end else if (left_ok) begin
          left_ok <= 1'b0;
          locked  <= 1'b1;
        end
      end
    end
  end

  // Partial words must not survive a reset, so the data path is cleared too.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_p0 <= '0;
      hold_l   <= '0;
    end else begin
      if (shift_en) shift_p0 <= {shift_p0[WIDTH-2:0], sd_s};
      if (vld_p1 && !slot_lr) hold_l <= shift_p0;
    end
  end

  assign push = vld_p1 && slot_lr && left_ok;

  // ---- Stage p2: frame FIFO (first-word-fall-through) ----
  logic [2*WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               full;
  logic               pop;
  logic               wr_en;
  logic               drop;
  logic [2*WIDTH-1:0] head;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign valid = (count != '0);
  assign pop   = valid && ready;
  // A same-cycle pop frees the slot the push needs.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {hold_l, shift_p0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      overflow_count <= 8'd0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow_count <= sat_inc8(overflow_count);
    end
  end

  assign head        = mem[rd_ptr];
  assign frame_out_l = valid ? head[2*WIDTH-1:WIDTH] : '0;
  assign frame_out_r = valid ? head[WIDTH-1:0]       : '0;
  assign level       = count;

endmodule

// File: tb/tb_i2s_receiver.sv
`timescale 1ns / 1ps
module tb_i2s_receiver;

  localparam int WIDTH       = 24;
  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             bclk = 1'b0;
  logic             lrclk = 1'b1;
  logic             sdata = 1'b0;
  logic             ready = 1'b0;
  logic [WIDTH-1:0] frame_out_l;
  logic [WIDTH-1:0] frame_out_r;
  logic             valid;
  logic [2:0]       level;
  logic             locked;
  logic [7:0]       overflow_count;

  int          vectors = 0;
  int          miscompares = 0;
  int          lat;
  logic [47:0] exp_q[$];
  event        lsb_ev;

  i2s_receiver #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .sdata         (sdata),
    .frame_out_l   (frame_out_l),
    .frame_out_r   (frame_out_r),
    .valid         (valid),
    .ready         (ready),
    .level         (level),
    .locked        (locked),
    .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every accepted frame is checked against the oldest
  // expected frame.
  always @(negedge clk) begin
    if (!reset && valid && ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame: got %h/%h, required no frame", frame_out_l, frame_out_r);
      end else begin
        check("frame", {frame_out_l, frame_out_r}, exp_q.pop_front());
      end
    end
  end

  // One bclk period = 16 clk periods; bclk edges land 3 ns after a clk edge.
  // lrclk and sdata change on the falling edge, as an I2S master drives them.
  task automatic bit_cycle(input logic lr, input logic d, input bit mark);
    @(posedge clk);
    #3;
    bclk  = 1'b0;
    lrclk = lr;
    sdata = d;
    repeat (8) @(posedge clk);
    #3;
    bclk = 1'b1;
    if (mark) ->lsb_ev;
    repeat (7) @(posedge clk);
  endtask

  // Bit 0 of a slot is the delay bit, bits 1..WIDTH carry the word MSB first.
  task automatic send_slot(input logic lr, input logic [WIDTH-1:0] w, input int nbits,
                           input bit mark_lsb);
    for (int i = 0; i < nbits; i++) begin
      logic d;
      d = (i >= 1 && i <= WIDTH) ? w[WIDTH-i] : 1'b0;
      bit_cycle(lr, d, mark_lsb && (i == WIDTH));
    end
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                            input bit mark_lsb);
    send_slot(1'b0, l, 32, 1'b0);
    send_slot(1'b1, r, 32, mark_lsb);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 ready = v;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check(name, 48'(exp_q.size()), 48'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},    48'(valid),          48'(0));
    check({tag, "_l"},        48'(frame_out_l),    48'(0));
    check({tag, "_r"},        48'(frame_out_r),    48'(0));
    check({tag, "_level"},    48'(level),          48'(0));
    check({tag, "_locked"},   48'(locked),         48'(0));
    check({tag, "_overflow"}, 48'(overflow_count), 48'(0));
  endtask

  initial begin
    // Reset while the bus toggles.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #2;
      bclk  = ~bclk;
      lrclk = ~lrclk;
      sdata = i[0];
    end
    check_reset_values("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    bclk  = 1'b0;
    lrclk = 1'b1;
    // Bit clock runs but lrclk stays put: nothing may be captured.
    for (int i = 0; i < 4; i++) bit_cycle(1'b1, 1'b1, 1'b0);
    check("idle_valid", 48'(valid), 48'(0));
    check("idle_level", 48'(level), 48'(0));

    // Single frame. valid follows the LSB pin rise by 4 clk edges: two
    // synchronizer edges give the rise cycle, one more the commit cycle,
    // and the FIFO write shows on the next.
    set_ready(1'b1);
    exp_q.push_back({24'hABCDEF, 24'h123456});
    fork
      send_frame(24'hABCDEF, 24'h123456, 1'b1);
      begin
        @(lsb_ev);
        lat = 0;
        while (!valid && lat < 20) begin
          @(posedge clk);
          #1;
          lat++;
        end
        check("valid_latency", 48'(lat), 48'(4));
      end
    join
    wait_drain("single_drain");
    check("single_locked", 48'(locked), 48'(1));
    check("single_level", 48'(level), 48'(0));

    // Short left slot: 16 bits, then lrclk toggles.
    send_slot(1'b0, 24'hDEAD01, 16, 1'b0);
    send_slot(1'b1, 24'h0F0F0F, 32, 1'b0);
    check("short_locked", 48'(locked), 48'(0));
    check("short_level", 48'(level), 48'(0));
    exp_q.push_back({24'h654321, 24'hFEDCBA});
    send_frame(24'h654321, 24'hFEDCBA, 1'b0);
    wait_drain("short_drain");
    check("short_relock", 48'(locked), 48'(1));

    // Overflow: six frames into a four-deep FIFO with the consumer stalled.
    set_ready(1'b0);
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) exp_q.push_back({24'(i), 24'h100000 | 24'(i)});
      send_frame(24'(i), 24'h100000 | 24'(i), 1'b0);
    end
    check("ovf_level", 48'(level), 48'(4));
    check("ovf_count", 48'(overflow_count), 48'(2));
    check("ovf_valid", 48'(valid), 48'(1));
    set_ready(1'b1);
    wait_drain("ovf_drain");
    repeat (2) @(posedge clk);
    #1;
    check("ovf_empty", 48'(valid), 48'(0));
    check("ovf_empty_l", 48'(frame_out_l), 48'(0));

    // Full FIFO, ready pulsed exactly in the push cycle.
    set_ready(1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({24'hA00000 | 24'(i), 24'hB00000 | 24'(i)});
      send_frame(24'hA00000 | 24'(i), 24'hB00000 | 24'(i), 1'b0);
    end
    check("full_level", 48'(level), 48'(4));
    exp_q.push_back({24'hA00004, 24'hB00004});
    fork
      send_frame(24'hA00004, 24'hB00004, 1'b1);
      begin
        @(lsb_ev);
        repeat (3) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    check("pp_level", 48'(level), 48'(4));
    check("pp_overflow", 48'(overflow_count), 48'(2));
    set_ready(1'b1);
    wait_drain("pp_drain");
    repeat (2) @(posedge clk);
    #1;
    check("pp_empty", 48'(valid), 48'(0));

    // Reset with data in the FIFO, released halfway through a right slot.
    set_ready(1'b0);
    exp_q.push_back({24'h0C0C0C, 24'h0D0D0D});
    send_frame(24'h0C0C0C, 24'h0D0D0D, 1'b0);
    check("pre_reset_level", 48'(level), 48'(1));
    fork
      begin
        send_slot(1'b0, 24'h5A5A5A, 32, 1'b0);
        send_slot(1'b1, 24'hA5A5A5, 32, 1'b0);
        send_slot(1'b0, 24'h135790, 32, 1'b0);
        send_slot(1'b1, 24'h2468AC, 32, 1'b0);
      end
      begin
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("midreset");
        repeat (664) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back({24'h135790, 24'h2468AC});
        ready = 1'b1;
      end
    join
    wait_drain("mid_drain");
    repeat (2) @(posedge clk);
    #1;
    check("mid_empty", 48'(valid), 48'(0));
    check("mid_locked", 48'(locked), 48'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
